// File: rtl/uart_rx_pkg.sv
// Shared types and baud helpers for the oversampled UART receiver.
package uart_rx_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_e;

  typedef enum logic [1:0] {ERR_NONE, ERR_FRAME, ERR_PARITY, ERR_OVERRUN} err_code_e;

  localparam int OVERSAMPLE = 16;

  localparam int BAUD_TABLE [8] = '{1200, 2400, 4800, 9600, 19200, 38400, 57600, 115200};

  // Clocks per oversample tick, truncated.
  function automatic int baud_div(input int clk_freq, input logic [2:0] sel);
    return clk_freq / (BAUD_TABLE[sel] * OVERSAMPLE);
  endfunction

endpackage

// File: rtl/uart_rx_sfifo.sv
// Synchronous RX FIFO; a push into a full FIFO only lands when a pop frees a slot in the same cycle.
module uart_rx_sfifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Storage is not reset, so the head is masked to zero while empty.
  assign pop_data = empty ? '0 : mem[rd_ptr];
  assign level    = count;

endmodule

// File: rtl/uart_rx_fifo_top.sv
// 16x oversampled UART receiver with majority voting, configurable frame format and RX FIFO.
// Drain handshake: the FIFO head pops on any rising edge where rx_valid_o and rx_ready_i are both high.
module uart_rx_fifo_top
  import uart_rx_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_n,
  input  logic                        uart_rx_i,
  input  logic [2:0]                  buad_set_i,
  output logic [DATA_BITS-1:0]        rx_data_o,
  output logic                        rx_valid_o,
  input  logic                        rx_ready_i,
  output logic                        rx_done_o,
  output logic                        rx_error_o,
  output logic [1:0]                  rx_err_code_o,
  output logic [$clog2(FIFO_DEPTH):0] rx_level_o,
  output state_e                      dbg_state_o
);

  localparam int DIV_TAB [8] = '{
    baud_div(CLK_FREQ, 3'd0), baud_div(CLK_FREQ, 3'd1),
    baud_div(CLK_FREQ, 3'd2), baud_div(CLK_FREQ, 3'd3),
    baud_div(CLK_FREQ, 3'd4), baud_div(CLK_FREQ, 3'd5),
    baud_div(CLK_FREQ, 3'd6), baud_div(CLK_FREQ, 3'd7)
  };
  localparam int   DIV_W     = $clog2(DIV_TAB[0]) + 1;
  localparam logic PAR_EN    = (PARITY_EN != 0);
  localparam logic PAR_ODD   = (PARITY_ODD != 0);
  localparam logic LAST_STOP = (STOP_BITS == 2);

  logic                 rx_s1, rx_s2, rx_prev;
  logic                 fall;
  state_e               state, state_nx;
  logic [DIV_W-1:0]     div_m1;
  logic [DIV_W-1:0]     tick_cnt;
  logic                 tick;
  logic [3:0]           samp;
  logic                 s7, s8, maj;
  logic                 at9, at15;
  logic [3:0]           bit_cnt;
  logic                 stop_cnt;
  logic [3:0]           brk_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_err;
  logic                 stop_bad, stop_good, parity_bad, frame_good, overrun, push;
  logic                 fifo_full, fifo_empty;
  err_code_e            code_q;

  // The two synchroniser flops plus a history flop for edge detection all idle high.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= uart_rx_i;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  assign fall = rx_prev && !rx_s2;

  // Divisor is re-latched every idle cycle, so it is frozen for the whole frame.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      div_m1 <= '0;
    end else if (state == IDLE) begin
      div_m1 <= DIV_W'(DIV_TAB[buad_set_i] - 1);
    end
  end

  assign tick = (state != IDLE) && (tick_cnt == div_m1);
  assign at9  = tick && (samp == 4'd9);
  assign at15 = tick && (samp == 4'd15);
  assign maj  = (s7 & s8) | (s7 & rx_s2) | (s8 & rx_s2);

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
      samp     <= '0;
      s7       <= 1'b1;
      s8       <= 1'b1;
    end else begin
      if (state == IDLE || tick) tick_cnt <= '0;
      else                       tick_cnt <= tick_cnt + DIV_W'(1);
      if (state == IDLE) samp <= '0;
      else if (tick)     samp <= samp + 4'd1;
      if (tick && samp == 4'd7) s7 <= rx_s2;
      if (tick && samp == 4'd8) s8 <= rx_s2;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:   if (fall) state_nx = START;
      START: begin
        if (at9 && maj) state_nx = IDLE;
        else if (at15)  state_nx = DATA;
      end
      DATA: begin
        if (at15 && bit_cnt == 4'(DATA_BITS - 1)) state_nx = PAR_EN ? PARITY : STOP;
      end
      PARITY: if (at15) state_nx = STOP;
      STOP: begin
        if (at9) begin
          if (!maj)                       state_nx = BREAK;
          else if (stop_cnt == LAST_STOP) state_nx = IDLE;
        end
      end
      BREAK:  if (tick && rx_s2 && brk_cnt == 4'd15) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      brk_cnt  <= '0;
      shreg    <= '0;
      par_err  <= 1'b0;
    end else begin
      if (state == START)            bit_cnt <= '0;
      else if (state == DATA && at15) bit_cnt <= bit_cnt + 4'd1;
      if (state != STOP) stop_cnt <= 1'b0;
      else if (at15)     stop_cnt <= 1'b1;
      if (state != BREAK) brk_cnt <= '0;
      else if (tick)      brk_cnt <= rx_s2 ? brk_cnt + 4'd1 : 4'd0;
      if (state == DATA && at9) shreg <= {maj, shreg[DATA_BITS-1:1]};
      if (state == IDLE)               par_err <= 1'b0;
      else if (state == PARITY && at9) par_err <= ((^shreg) ^ maj) != PAR_ODD;
    end
  end

  // Frame-end resolution: framing beats parity beats overrun.
  assign stop_bad   = (state == STOP) && at9 && !maj;
  assign stop_good  = (state == STOP) && at9 && maj && (stop_cnt == LAST_STOP);
  assign parity_bad = stop_good && PAR_EN && par_err;
  assign frame_good = stop_good && !parity_bad;
  assign overrun    = frame_good && fifo_full && !rx_ready_i;
  assign push       = frame_good && !overrun;

  assign rx_done_o  = push;
  assign rx_error_o = stop_bad || parity_bad || overrun;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      code_q <= ERR_NONE;
    end else if (rx_error_o) begin
      if (stop_bad)        code_q <= ERR_FRAME;
      else if (parity_bad) code_q <= ERR_PARITY;
      else                 code_q <= ERR_OVERRUN;
    end
  end

  uart_rx_sfifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (shreg),
    .pop       (rx_ready_i),
    .pop_data  (rx_data_o),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (rx_level_o)
  );

  assign rx_valid_o    = !fifo_empty;
  assign rx_err_code_o = code_q;
  assign dbg_state_o   = state;

endmodule

// File: tb/tb_uart_rx_fifo_top.sv
// Bench for uart_rx_fifo_top: three configurations (8N1, 8E1, 5N2) on one clock.
// The clock frequency is scaled down so every baud setting yields a short bit time.
module tb_uart_rx_fifo_top;
  import uart_rx_pkg::*;

  localparam int CLK_F = 7_372_800;
  localparam int BAUD [8] = '{1200, 2400, 4800, 9600, 19200, 38400, 57600, 115200};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic       a_line = 1'b1, p_line = 1'b1, f_line = 1'b1;
  logic [2:0] a_sel = 3'd7, p_sel = 3'd7, f_sel = 3'd3;
  logic       a_ready = 1'b0, p_ready = 1'b0, f_ready = 1'b0;
  logic [7:0] a_data, p_data;
  logic [4:0] f_data;
  logic       a_valid, p_valid, f_valid;
  logic       a_done, p_done, f_done;
  logic       a_err, p_err, f_err;
  logic [1:0] a_code, p_code, f_code;
  logic [3:0] a_level, p_level, f_level;
  state_e     a_state, p_state, f_state;

  uart_rx_fifo_top #(.CLK_FREQ(CLK_F)) dut_a (
    .clk_i(clk), .rst_n(rst_n), .uart_rx_i(a_line), .buad_set_i(a_sel),
    .rx_data_o(a_data), .rx_valid_o(a_valid), .rx_ready_i(a_ready),
    .rx_done_o(a_done), .rx_error_o(a_err), .rx_err_code_o(a_code),
    .rx_level_o(a_level), .dbg_state_o(a_state));

  uart_rx_fifo_top #(.CLK_FREQ(CLK_F), .PARITY_EN(1), .PARITY_ODD(0)) dut_p (
    .clk_i(clk), .rst_n(rst_n), .uart_rx_i(p_line), .buad_set_i(p_sel),
    .rx_data_o(p_data), .rx_valid_o(p_valid), .rx_ready_i(p_ready),
    .rx_done_o(p_done), .rx_error_o(p_err), .rx_err_code_o(p_code),
    .rx_level_o(p_level), .dbg_state_o(p_state));

  uart_rx_fifo_top #(.CLK_FREQ(CLK_F), .DATA_BITS(5), .STOP_BITS(2)) dut_f (
    .clk_i(clk), .rst_n(rst_n), .uart_rx_i(f_line), .buad_set_i(f_sel),
    .rx_data_o(f_data), .rx_valid_o(f_valid), .rx_ready_i(f_ready),
    .rx_done_o(f_done), .rx_error_o(f_err), .rx_err_code_o(f_code),
    .rx_level_o(f_level), .dbg_state_o(f_state));

  // ---------------- monitors / scoreboard ----------------
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int a_done_n = 0, a_err_n = 0, a_done_cyc = 0, a_pop_cyc = 0;
  int p_done_n = 0, p_err_n = 0;
  int f_done_n = 0, f_err_n = 0;
  int both_n = 0;
  logic [7:0] a_pop_q[$];
  logic [7:0] p_pop_q[$];
  logic [4:0] f_pop_q[$];
  logic [7:0] exp_q[$];
  logic [1:0] exp_code_a = 2'd0;

  always @(negedge clk) begin
    cyc++;
    if (a_done) begin a_done_n++; a_done_cyc = cyc; end
    if (a_err) a_err_n++;
    if (p_done) p_done_n++;
    if (p_err) p_err_n++;
    if (f_done) f_done_n++;
    if (f_err) f_err_n++;
    if ((a_done && a_err) || (p_done && p_err) || (f_done && f_err)) both_n++;
    if (a_valid && a_ready) begin a_pop_q.push_back(a_data); a_pop_cyc = cyc; end
    if (p_valid && p_ready) p_pop_q.push_back(p_data);
    if (f_valid && f_ready) f_pop_q.push_back(f_data);
  end

  // ---------------- driver tasks ----------------
  function automatic int bit_clks(int sel);
    return 16 * (CLK_F / (BAUD[sel] * 16));
  endfunction

  task automatic hold(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_line(int inst, logic v);
    case (inst)
      0: a_line = v;
      1: p_line = v;
      default: f_line = v;
    endcase
  endtask

  task automatic send_frame(int inst, logic [8:0] data, int nbits, int par, logic pbit,
                            int nstop, int sel);
    int bc;
    bc = bit_clks(sel);
    set_line(inst, 1'b0);
    hold(bc);
    for (int i = 0; i < nbits; i++) begin
      set_line(inst, data[i]);
      hold(bc);
    end
    if (par != 0) begin
      set_line(inst, pbit);
      hold(bc);
    end
    set_line(inst, 1'b1);
    hold(bc * nstop);
  endtask

  task automatic set_ready_a(logic v);
    @(posedge clk);
    #1 a_ready = v;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    hold(3);
    checks++;
    if ({a_data, a_valid, a_done, a_err, a_code, a_level} !== '0) begin
      errors++; $display("FAIL reset_a: got %0h expected 0", {a_data, a_valid, a_done, a_err, a_code, a_level});
    end
    checks++;
    if ({p_data, p_valid, p_done, p_err, p_code, p_level} !== '0) begin
      errors++; $display("FAIL reset_p: got %0h expected 0", {p_data, p_valid, p_done, p_err, p_code, p_level});
    end
    checks++;
    if ({f_data, f_valid, f_done, f_err, f_code, f_level} !== '0) begin
      errors++; $display("FAIL reset_f: got %0h expected 0", {f_data, f_valid, f_done, f_err, f_code, f_level});
    end
    rst_n = 1'b1;
    hold(3);
    checks++;
    if (a_state !== IDLE) begin
      errors++; $display("FAIL reset_state: got %0d expected %0d", a_state, IDLE);
    end
  endtask

  task automatic test_single_8n1();
    int d0, e0;
    d0 = a_done_n; e0 = a_err_n;
    a_pop_q.delete();
    set_ready_a(1'b1);
    hold(2);
    send_frame(0, 9'h0A5, 8, 0, 1'b0, 1, 7);
    hold(2 * bit_clks(7));
    checks++;
    if (a_done_n - d0 != 1) begin
      errors++; $display("FAIL single_done: got %0d expected 1", a_done_n - d0);
    end
    checks++;
    if (a_err_n - e0 != 0) begin
      errors++; $display("FAIL single_err: got %0d expected 0", a_err_n - e0);
    end
    checks++;
    if (a_pop_q.size() != 1 || a_pop_q[0] !== 8'hA5) begin
      errors++; $display("FAIL single_data: got %0d items head %0h expected 1 item a5",
                         a_pop_q.size(), (a_pop_q.size() > 0) ? a_pop_q[0] : 8'h00);
    end
    checks++;
    if (a_pop_cyc - a_done_cyc != 1) begin
      errors++; $display("FAIL single_latency: got %0d expected 1", a_pop_cyc - a_done_cyc);
    end
    checks++;
    if ({a_code, a_level, a_valid} !== 7'd0) begin
      errors++; $display("FAIL single_idle: got code %0d level %0d valid %0b expected 0 0 0",
                         a_code, a_level, a_valid);
    end
  endtask

  task automatic test_baud_latch();
    int d0;
    d0 = a_done_n;
    a_pop_q.delete();
    fork
      send_frame(0, 9'h0C3, 8, 0, 1'b0, 1, 7);
      begin
        hold(3 * bit_clks(7));
        a_sel = 3'd5;
      end
    join
    hold(bit_clks(7));
    a_sel = 3'd7;
    hold(2 * bit_clks(7));
    checks++;
    if (a_done_n - d0 != 1 || a_pop_q.size() != 1 || a_pop_q[0] !== 8'hC3) begin
      errors++; $display("FAIL baud_latch: got %0d frames head %0h expected 1 frame c3",
                         a_done_n - d0, (a_pop_q.size() > 0) ? a_pop_q[0] : 8'h00);
    end
  endtask

  task automatic test_glitch();
    int d0, e0;
    d0 = a_done_n; e0 = a_err_n;
    a_line = 1'b0;
    hold(8);
    checks++;
    if (a_state !== START) begin
      errors++; $display("FAIL glitch_start: got %0d expected %0d", a_state, START);
    end
    hold(4);
    a_line = 1'b1;
    hold(2 * bit_clks(7));
    checks++;
    if (a_done_n - d0 != 0 || a_err_n - e0 != 0) begin
      errors++; $display("FAIL glitch_events: got done %0d err %0d expected 0 0", a_done_n - d0, a_err_n - e0);
    end
    checks++;
    if (a_state !== IDLE) begin
      errors++; $display("FAIL glitch_idle: got %0d expected %0d", a_state, IDLE);
    end
  endtask

  task automatic test_overflow();
    int d0, e0, ovr;
    d0 = a_done_n; e0 = a_err_n; ovr = 0;
    set_ready_a(1'b0);
    exp_q.delete();
    a_pop_q.delete();
    for (int i = 0; i < 9; i++) begin
      send_frame(0, 9'(i), 8, 0, 1'b0, 1, 7);
      hold(bit_clks(7));
      if (exp_q.size() < 8) exp_q.push_back(8'(i));
      else ovr++;
    end
    if (ovr > 0) exp_code_a = 2'd3;
    checks++;
    if (a_level !== 4'd8) begin
      errors++; $display("FAIL ovf_level: got %0d expected 8", a_level);
    end
    checks++;
    if (a_err_n - e0 != ovr || a_done_n - d0 != 9 - ovr) begin
      errors++; $display("FAIL ovf_counts: got err %0d done %0d expected %0d %0d",
                         a_err_n - e0, a_done_n - d0, ovr, 9 - ovr);
    end
    checks++;
    if (a_code !== exp_code_a) begin
      errors++; $display("FAIL ovf_code: got %0d expected %0d", a_code, exp_code_a);
    end
    set_ready_a(1'b1);
    for (int k = 0; k < 40 && a_level != 0; k++) hold(1);
    set_ready_a(1'b0);
    hold(2);
    checks++;
    if (a_pop_q.size() != exp_q.size()) begin
      errors++; $display("FAIL ovf_drain_count: got %0d expected %0d", a_pop_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < a_pop_q.size(); i++) begin
      checks++;
      if (a_pop_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL ovf_order[%0d]: got %0h expected %0h", i, a_pop_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_break();
    int d0, e0, dv;
    d0 = a_done_n; e0 = a_err_n;
    dv = bit_clks(7) / 16;
    set_ready_a(1'b1);
    a_pop_q.delete();
    a_line = 1'b0;
    hold(15 * bit_clks(7));
    checks++;
    if (a_state !== BREAK) begin
      errors++; $display("FAIL break_state: got %0d expected %0d", a_state, BREAK);
    end
    hold(5 * bit_clks(7));
    a_line = 1'b1;
    hold(8 * dv);
    checks++;
    if (a_state !== BREAK) begin
      errors++; $display("FAIL break_hold: got %0d expected %0d", a_state, BREAK);
    end
    hold(12 * dv);
    checks++;
    if (a_state !== IDLE) begin
      errors++; $display("FAIL break_exit: got %0d expected %0d", a_state, IDLE);
    end
    exp_code_a = 2'd1;
    checks++;
    if (a_err_n - e0 != 1 || a_done_n - d0 != 0 || a_code !== exp_code_a) begin
      errors++; $display("FAIL break_err: got err %0d done %0d code %0d expected 1 0 1",
                         a_err_n - e0, a_done_n - d0, a_code);
    end
    send_frame(0, 9'h05A, 8, 0, 1'b0, 1, 7);
    hold(2 * bit_clks(7));
    checks++;
    if (a_pop_q.size() != 1 || a_pop_q[0] !== 8'h5A) begin
      errors++; $display("FAIL break_after: got %0d items head %0h expected 1 item 5a",
                         a_pop_q.size(), (a_pop_q.size() > 0) ? a_pop_q[0] : 8'h00);
    end
  endtask

  task automatic test_random_fifo();
    int n, d0, e0, ovr, sel, exp_lvl;
    logic [7:0] d;
    n = $urandom_range(6, 11);
    d0 = a_done_n; e0 = a_err_n; ovr = 0;
    set_ready_a(1'b0);
    exp_q.delete();
    a_pop_q.delete();
    for (int i = 0; i < n; i++) begin
      sel = $urandom_range(6, 7);
      a_sel = 3'(sel);
      hold(2);
      d = 8'($urandom);
      send_frame(0, {1'b0, d}, 8, 0, 1'b0, 1, sel);
      hold(bit_clks(sel) / 2 + $urandom_range(1, 40));
      if (exp_q.size() < 8) exp_q.push_back(d);
      else ovr++;
    end
    a_sel = 3'd7;
    if (ovr > 0) exp_code_a = 2'd3;
    exp_lvl = exp_q.size();
    checks++;
    if (a_level !== 4'(exp_lvl)) begin
      errors++; $display("FAIL rand_level: got %0d expected %0d", a_level, exp_lvl);
    end
    checks++;
    if (a_err_n - e0 != ovr || a_done_n - d0 != n - ovr || a_code !== exp_code_a) begin
      errors++; $display("FAIL rand_counts: got err %0d done %0d code %0d expected %0d %0d %0d",
                         a_err_n - e0, a_done_n - d0, a_code, ovr, n - ovr, exp_code_a);
    end
    for (int k = 0; k < 600 && a_level != 0; k++) set_ready_a(1'($urandom_range(0, 1)));
    set_ready_a(1'b0);
    hold(2);
    checks++;
    if (a_pop_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rand_drain_count: got %0d expected %0d", a_pop_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < a_pop_q.size(); i++) begin
      checks++;
      if (a_pop_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL rand_order[%0d]: got %0h expected %0h", i, a_pop_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_parity();
    int d0, e0, exp_err;
    logic [7:0] d;
    logic flip;
    d0 = p_done_n; e0 = p_err_n; exp_err = 1;
    p_ready = 1'b1;
    p_pop_q.delete();
    exp_q.delete();
    hold(2);
    send_frame(1, 9'h003, 8, 1, 1'b1, 1, 7);
    hold(2 * bit_clks(7));
    checks++;
    if (p_err_n - e0 != 1 || p_done_n - d0 != 0 || p_code !== 2'd2 || p_level !== 4'd0) begin
      errors++; $display("FAIL parity_03: got err %0d done %0d code %0d level %0d expected 1 0 2 0",
                         p_err_n - e0, p_done_n - d0, p_code, p_level);
    end
    for (int i = 0; i < 7; i++) begin
      d = 8'($urandom);
      flip = 1'($urandom_range(0, 1));
      // Even parity: the parity bit makes the total count of ones even.
      send_frame(1, {1'b0, d}, 8, 1, 1'($countones(d) % 2) ^ flip, 1, 7);
      hold(bit_clks(7));
      if (flip) exp_err++;
      else exp_q.push_back(d);
    end
    hold(bit_clks(7));
    checks++;
    if (p_err_n - e0 != exp_err || p_done_n - d0 != exp_q.size()) begin
      errors++; $display("FAIL parity_counts: got err %0d done %0d expected %0d %0d",
                         p_err_n - e0, p_done_n - d0, exp_err, exp_q.size());
    end
    checks++;
    if (p_code !== 2'd2 || p_level !== 4'd0) begin
      errors++; $display("FAIL parity_state: got code %0d level %0d expected 2 0", p_code, p_level);
    end
    checks++;
    if (p_pop_q.size() != exp_q.size()) begin
      errors++; $display("FAIL parity_data_count: got %0d expected %0d", p_pop_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < p_pop_q.size(); i++) begin
      checks++;
      if (p_pop_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL parity_data[%0d]: got %0h expected %0h", i, p_pop_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_five_bit();
    int d0, bc;
    logic [4:0] d;
    d0 = f_done_n;
    bc = bit_clks(3);
    f_ready = 1'b0;
    send_frame(2, 9'h015, 5, 0, 1'b0, 2, 3);
    hold(bc);
    checks++;
    if (f_done_n - d0 != 1 || f_level !== 4'd1 || f_valid !== 1'b1 || f_data !== 5'h15) begin
      errors++; $display("FAIL five_bit: got done %0d level %0d valid %0b data %0h expected 1 1 1 15",
                         f_done_n - d0, f_level, f_valid, f_data);
    end
  endtask

  task automatic test_reset_mid_frame();
    int bc;
    logic [4:0] d;
    bc = bit_clks(3);
    d = 5'h15;
    f_line = 1'b0;
    hold(bc);
    f_line = d[0];
    hold(bc);
    f_line = d[1];
    hold(bc);
    f_line = d[2];
    hold(bc / 2);
    rst_n = 1'b0;
    f_line = 1'b1;
    hold(3);
    checks++;
    if ({f_data, f_valid, f_done, f_err, f_code, f_level} !== '0 || f_state !== IDLE) begin
      errors++; $display("FAIL reset_mid: got %0h state %0d expected 0 %0d",
                         {f_data, f_valid, f_done, f_err, f_code, f_level}, f_state, IDLE);
    end
    rst_n = 1'b1;
    hold(2 * bc);
    send_frame(2, 9'h00A, 5, 0, 1'b0, 2, 3);
    hold(bc);
    checks++;
    if (f_level !== 4'd1 || f_data !== 5'h0A || f_err_n != 0) begin
      errors++; $display("FAIL after_reset: got level %0d data %0h errs %0d expected 1 0a 0",
                         f_level, f_data, f_err_n);
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_single_8n1();
    test_baud_latch();
    test_glitch();
    test_overflow();
    test_break();
    test_random_fifo();
    test_parity();
    test_five_bit();
    test_reset_mid_frame();
    checks++;
    if (both_n != 0) begin
      errors++; $display("FAIL done_and_error: got %0d overlaps expected 0", both_n);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #950000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
